lfsr_gen: RTL and testbench

//   Parametrised Fibonacci LFSR pseudo-random byte generator; successor to the fixed 32-bit LFSR.

---
 rtl/lfsr_gen.sv | 139 +++++++++++++
 tb/tb_lfsr_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR byte generator with N-step burst engine and valid/ready output.
// Define LFSR_LOCKUP_FIX_EN to force the all-zero state back to SEED on load and advance.
module lfsr_gen #(
  parameter int                 WIDTH = 32,
  parameter logic [WIDTH-1:0]   TAPS  = 32'h40001064,
  parameter logic [WIDTH-1:0]   SEED  = 32'h00000001,
  parameter int                 CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             ld_lfsr,
  input  logic             step,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lfsr_val,
  output logic [7:0]       psr_byte,
  output logic             psr_valid,
  input  logic             psr_ready
);

  localparam int NB = (WIDTH + 7) / 8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] lfsr_nxt;
  logic             fb;
  logic             adv_ok;
  logic             adv;

  function automatic logic [7:0] fold(input logic [WIDTH-1:0] v);
    logic [NB*8-1:0] pad;
    logic [7:0]      acc;
    pad = '0;
    pad[WIDTH-1:0] = v;
    acc = 8'h80;
    for (int i = 0; i < NB; i++) begin
      acc = acc ^ pad[i*8 +: 8];
    end
    return acc;
  endfunction

  always_comb begin
    fb       = ^(lfsr_q & TAPS);
    lfsr_nxt = {lfsr_q[WIDTH-2:0], fb};
`ifdef LFSR_LOCKUP_FIX_EN
    if (lfsr_q == '0) lfsr_nxt = SEED;
`endif
  end

  assign adv_ok = !valid_q || psr_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    byte_d  = byte_q;
    valid_d = valid_q && !psr_ready;
    done_d  = 1'b0;
    adv     = 1'b0;

    if (ld_lfsr) begin
      lfsr_d  = ld_val;
`ifdef LFSR_LOCKUP_FIX_EN
      if (ld_val == '0) lfsr_d = SEED;
`endif
      valid_d = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // burst_start wins over a coincident step
          if (burst_start) begin
            if (burst_len == '0) begin
              done_d = 1'b1;
            end else begin
              cnt_d   = burst_len;
              state_d = RUN;
            end
          end else if (step && adv_ok) begin
            adv = 1'b1;
          end
        end
        RUN: begin
          if (adv_ok) begin
            adv   = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (adv) begin
      lfsr_d  = lfsr_nxt;
      byte_d  = fold(lfsr_nxt);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign lfsr_val  = lfsr_q;
  assign psr_byte  = byte_q;
  assign psr_valid = valid_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: expected bytes queued at stimulus time, popped on each handshake.
module tb_lfsr_gen;

  localparam logic [31:0] T_SEED = 32'h00000001;
  localparam logic [31:0] T_TAPS = 32'h40001064;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ld_val;
  logic        ld_lfsr;
  logic        step;
  logic        burst_start;
  logic [15:0] burst_len;
  logic        busy;
  logic        done;
  logic [31:0] lfsr_val;
  logic [7:0]  psr_byte;
  logic        psr_valid;
  logic        psr_ready;

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk(clk), .rst(rst), .ld_val(ld_val), .ld_lfsr(ld_lfsr), .step(step),
    .burst_start(burst_start), .burst_len(burst_len), .busy(busy), .done(done),
    .lfsr_val(lfsr_val), .psr_byte(psr_byte), .psr_valid(psr_valid), .psr_ready(psr_ready)
  );

  typedef struct packed {
    logic [31:0] v;
    logic [7:0]  b;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_next(input logic [31:0] v);
    logic fb;
`ifdef LFSR_LOCKUP_FIX_EN
    if (v == 32'h0) return T_SEED;
`endif
    fb = 1'b0;
    for (int i = 0; i < 32; i++) if (T_TAPS[i]) fb = fb ^ v[i];
    return {v[30:0], fb};
  endfunction

  function automatic logic [7:0] m_fold(input logic [31:0] v);
    logic [7:0] b;
    b = 8'h80;
    for (int i = 0; i < 32; i++) b[i % 8] = b[i % 8] ^ v[i];
    return b;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] v);
`ifdef LFSR_LOCKUP_FIX_EN
    if (v == 32'h0) return T_SEED;
`endif
    return v;
  endfunction

  task automatic push_adv();
    m = m_next(m);
    sb.push_back({m, m_fold(m)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] v);
    ld_lfsr = 1'b1;
    ld_val  = v;
    tick();
    ld_lfsr = 1'b0;
    m = m_load(v);
  endtask

  always @(negedge clk) begin
    if (!rst && psr_valid && psr_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_byte", {56'd0, psr_byte}, {56'd0, mon_e.b});
        chk("sb_val", {32'd0, lfsr_val}, {32'd0, mon_e.v});
      end
    end
  end

  int busy_n, done_n;
  logic [31:0] seq4 [4];

  initial begin
    seq4[0] = 32'h2; seq4[1] = 32'h4; seq4[2] = 32'h9; seq4[3] = 32'h12;
    rst = 1'b1; ld_val = '0; ld_lfsr = 0; step = 0; burst_start = 0; burst_len = '0;
    psr_ready = 1'b1;
    m = T_SEED;
    tick(); tick();
    chk("rst_val", {32'd0, lfsr_val}, 64'h1);
    chk("rst_valid", {63'd0, psr_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_byte", {56'd0, psr_byte}, 64'd0);
    rst = 1'b0;

    // single step from SEED
    step = 1'b1; push_adv();
    tick();
    step = 1'b0;
    chk("step_val", {32'd0, lfsr_val}, 64'h2);
    chk("step_byte", {56'd0, psr_byte}, 64'h82);
    chk("step_valid", {63'd0, psr_valid}, 64'd1);

    load(32'h40000000);
    chk("ld_val", {32'd0, lfsr_val}, 64'h40000000);
    step = 1'b1; push_adv();
    tick();
    step = 1'b0;
    chk("step2_val", {32'd0, lfsr_val}, 64'h80000001);
    tick();

    // burst of 4
    load(T_SEED);
    burst_start = 1'b1; burst_len = 16'd4;
    for (int i = 0; i < 4; i++) push_adv();
    tick();
    burst_start = 1'b0;
    busy_n = 0; done_n = 0;
    for (int k = 0; k < 8; k++) begin
      busy_n += int'(busy);
      done_n += int'(done);
      tick();
      if (k < 4) chk("burst_seq", {32'd0, lfsr_val}, {32'd0, seq4[k]});
    end
    chk("burst_busy_n", 64'(busy_n), 64'd4);
    chk("burst_done_n", 64'(done_n), 64'd1);

    // zero-length burst
    burst_start = 1'b1; burst_len = 16'd0;
    tick();
    burst_start = 1'b0;
    chk("len0_done", {63'd0, done}, 64'd1);
    chk("len0_busy", {63'd0, busy}, 64'd0);
    chk("len0_val", {32'd0, lfsr_val}, {32'd0, m});
    tick();
    chk("len0_done_clr", {63'd0, done}, 64'd0);

    // burst of 3 with backpressure
    load(T_SEED);
    burst_start = 1'b1; burst_len = 16'd3;
    for (int i = 0; i < 3; i++) push_adv();
    tick();
    burst_start = 1'b0;
    psr_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("bp_val", {32'd0, lfsr_val}, 64'h2);
    chk("bp_byte", {56'd0, psr_byte}, 64'h82);
    chk("bp_busy", {63'd0, busy}, 64'd1);
    psr_ready = 1'b1;
    done_n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      done_n += int'(done);
    end
    chk("bp_done_n", 64'(done_n), 64'd1);
    chk("bp_final", {32'd0, lfsr_val}, 64'h9);

    // load aborts a burst of 8
    load(T_SEED);
    burst_start = 1'b1; burst_len = 16'd8;
    for (int i = 0; i < 8; i++) push_adv();
    tick();
    burst_start = 1'b0;
    tick();
    ld_lfsr = 1'b1; ld_val = 32'hDEADBEEF;
    tick();
    ld_lfsr = 1'b0;
    sb.delete();
    m = 32'hDEADBEEF;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {63'd0, psr_valid}, 64'd0);
    chk("abort_val", {32'd0, lfsr_val}, 64'hDEADBEEF);
    done_n = int'(done);
    for (int k = 0; k < 3; k++) begin
      tick();
      done_n += int'(done);
    end
    chk("abort_done_n", 64'(done_n), 64'd0);

    // reset in the middle of a burst
    load(T_SEED);
    burst_start = 1'b1; burst_len = 16'd5;
    for (int i = 0; i < 5; i++) push_adv();
    tick();
    burst_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    sb.delete();
    m = T_SEED;
    chk("mrst_val", {32'd0, lfsr_val}, 64'h1);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_valid", {63'd0, psr_valid}, 64'd0);
    tick();
    chk("mrst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    // all-zero state
    load(32'h0);
`ifdef LFSR_LOCKUP_FIX_EN
    chk("zero_ld", {32'd0, lfsr_val}, 64'h1);
`else
    chk("zero_ld", {32'd0, lfsr_val}, 64'h0);
`endif
    step = 1'b1; push_adv();
    tick();
    step = 1'b0;
`ifdef LFSR_LOCKUP_FIX_EN
    chk("zero_step_val", {32'd0, lfsr_val}, 64'h2);
    chk("zero_step_byte", {56'd0, psr_byte}, 64'h82);
`else
    chk("zero_step_val", {32'd0, lfsr_val}, 64'h0);
    chk("zero_step_byte", {56'd0, psr_byte}, 64'h80);
`endif
    tick(); tick();
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
